huff_freq_counter: RTL and testbench



---
 rtl/huff_pkg.sv | 21 ++
 rtl/huff_sym_cam.sv | 31 +++
 rtl/huff_freq_counter.sv | 133 +++++++++++++
 tb/tb_huff_freq_counter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared widths, flag constants and state type for the Huffman front end.
// The collator imports the same package so entry layouts stay in lockstep.
package huff_pkg;

    localparam int SYM_W   = 8;
    localparam int CNT_W   = 6;
    localparam int ENTRY_W = 1 + SYM_W + CNT_W;

    localparam logic LEAF = 1'b0;
    localparam logic NODE = 1'b1;

    localparam logic [CNT_W-1:0] EMPTY_FREQ = 6'h3F;
    localparam logic [CNT_W-1:0] MAX_FREQ   = 6'h3E;

    typedef enum logic [1:0] {
        S_COUNT,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/huff_sym_cam.sv
// Parallel symbol lookup over the counter's table; returns hit and index.
// Stored symbols are distinct, so at most one match bit is ever set.
module huff_sym_cam
    import huff_pkg::*;
#(
    parameter int NUM_SYM = 8,
    parameter int IDX_W   = $clog2(NUM_SYM)
) (
    input  logic [NUM_SYM-1:0][SYM_W-1:0] syms,
    input  logic [NUM_SYM-1:0]            vld,
    input  logic [SYM_W-1:0]              key,
    output logic                          hit,
    output logic [IDX_W-1:0]              hit_idx
);

    logic [NUM_SYM-1:0] match;

    always_comb begin
        match   = '0;
        hit_idx = '0;
        for (int i = 0; i < NUM_SYM; i++) begin
            match[i] = vld[i] && (syms[i] == key);
            if (match[i]) begin
                hit_idx = hit_idx | IDX_W'(i);
            end
        end
    end

    assign hit = |match;

endmodule

// File: rtl/huff_freq_counter.sv
// Symbol frequency table feeding the Huffman collator, one leaf per cycle.
// Build with HUFF_FREQ_SAT_EN to saturate counts silently at MAX_FREQ.
module huff_freq_counter
    import huff_pkg::*;
#(
    parameter int NUM_SYM = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sym_valid,
    input  logic [SYM_W-1:0]         sym_data,
    input  logic                     sym_last,
    output logic                     sym_ready,
    output logic                     down,
    output logic [ENTRY_W-1:0]       group_data,
    output logic [$clog2(NUM_SYM):0] n_sym,
    output logic                     done,
    output logic                     err_ovf
);

    localparam int IDX_W = $clog2(NUM_SYM);
    localparam int N_W   = IDX_W + 1;

    state_t state, state_nx;

    logic [NUM_SYM-1:0][SYM_W-1:0] sym_tab;
    logic [NUM_SYM-1:0][CNT_W-1:0] cnt_tab;
    logic [NUM_SYM-1:0]            vld;
    logic [IDX_W-1:0]              emit_idx;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             accept;
    logic             full;
    logic             last_emit;

    huff_sym_cam #(
        .NUM_SYM (NUM_SYM),
        .IDX_W   (IDX_W)
    ) u_cam (
        .syms    (sym_tab),
        .vld     (vld),
        .key     (sym_data),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    assign sym_ready = (state == S_COUNT);
    assign accept    = sym_valid && sym_ready;
    assign full      = (n_sym == N_W'(NUM_SYM));
    assign last_emit = ({1'b0, emit_idx} == (n_sym - 1'b1));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_COUNT: begin
                if (accept && sym_last) begin
                    state_nx = S_EMIT;
                end
            end
            S_EMIT: begin
                if ((n_sym == '0) || last_emit) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_COUNT;
            default: state_nx = S_COUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_COUNT;
            sym_tab    <= '0;
            cnt_tab    <= '0;
            vld        <= '0;
            n_sym      <= '0;
            emit_idx   <= '0;
            down       <= 1'b0;
            group_data <= '0;
            done       <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            state <= state_nx;
            down  <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                S_COUNT: begin
                    emit_idx <= '0;
                    if (accept) begin
                        if (hit) begin
                            if (cnt_tab[hit_idx] != MAX_FREQ) begin
                                cnt_tab[hit_idx] <= cnt_tab[hit_idx] + 1'b1;
                            end else begin
`ifdef HUFF_FREQ_SAT_EN
                                err_ovf <= err_ovf;
`else
                                err_ovf <= 1'b1;
`endif
                            end
                        end else if (!full) begin
                            sym_tab[n_sym[IDX_W-1:0]] <= sym_data;
                            cnt_tab[n_sym[IDX_W-1:0]] <= CNT_W'(1);
                            vld[n_sym[IDX_W-1:0]]     <= 1'b1;
                            n_sym                     <= n_sym + 1'b1;
                        end else begin
                            err_ovf <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (n_sym != '0) begin
                        down       <= 1'b1;
                        group_data <= {LEAF, sym_tab[emit_idx],
                                       cnt_tab[emit_idx]};
                        emit_idx   <= emit_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done       <= 1'b1;
                    sym_tab    <= '0;
                    cnt_tab    <= '0;
                    vld        <= '0;
                    n_sym      <= '0;
                    err_ovf    <= 1'b0;
                    group_data <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_huff_freq_counter.sv
// Directed bench for huff_freq_counter: block table plus reset/overflow cases.
// Expected leaf words are written out by hand as {0, symbol, freq}.
module tb_huff_freq_counter;

    logic        clk;
    logic        rst;
    logic        sym_valid;
    logic [7:0]  sym_data;
    logic        sym_last;
    logic        sym_ready;
    logic        down;
    logic [14:0] group_data;
    logic [3:0]  n_sym;
    logic        done;
    logic        err_ovf;

    int total = 0;
    int bad   = 0;

    huff_freq_counter #(.NUM_SYM(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_last   (sym_last),
        .sym_ready  (sym_ready),
        .down       (down),
        .group_data (group_data),
        .n_sym      (n_sym),
        .done       (done),
        .err_ovf    (err_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [9:0][7:0]  syms;
        int               nsyms;
        int               exp_n;
        logic [7:0][14:0] exp_ent;
        logic             exp_ovf;
        logic             hold_aa;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        for (int i = 0; i < v.nsyms; i++) begin
            @(negedge clk);
            sym_valid = 1'b1;
            sym_data  = v.syms[i];
            sym_last  = (i == v.nsyms - 1);
            @(posedge clk);
        end
    endtask

    task automatic send_rep(input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sym_valid = 1'b1;
            sym_data  = s;
            sym_last  = (i == n - 1);
            @(posedge clk);
        end
    endtask

    task automatic collect(input vec_t v);
        int ent;
        int first_k;
        int done_k;
        ent     = 0;
        first_k = -1;
        done_k  = -1;
        for (int k = 0; k < 24 && done_k < 0; k++) begin
            @(negedge clk);
            if (!v.hold_aa || done) begin
                sym_valid = 1'b0;
                sym_last  = 1'b0;
            end else begin
                sym_valid = 1'b1;
                sym_data  = 8'hAA;
                sym_last  = 1'b0;
            end
            if (down) begin
                if (first_k < 0) first_k = k;
                if (ent < 8) chk("entry", group_data, v.exp_ent[ent]);
                chk("ovf_emit", err_ovf, v.exp_ovf);
                chk("nsym_emit", n_sym, v.exp_n);
                chk("ready_emit", sym_ready, 0);
                ent++;
            end
            if (v.hold_aa && k <= v.exp_n) chk("ready_hold", sym_ready, 0);
            if (done) done_k = k;
        end
        chk("first_down_lat", first_k, 1);
        chk("n_entries", ent, v.exp_n);
        chk("done_lat", done_k, v.exp_n + 1);
        chk("nsym_cleared", n_sym, 0);
        chk("ovf_cleared", err_ovf, 0);
        chk("ready_after", sym_ready, 1);
    endtask

    vec_t v70;
    vec_t vr;
    vec_t v1;
    int   dcnt;

    initial begin
        for (int i = 0; i < 5; i++) vt[i] = '0;
        vt[0].syms[0] = 8'h41; vt[0].syms[1] = 8'h42;
        vt[0].syms[2] = 8'h41; vt[0].syms[3] = 8'h43;
        vt[0].syms[4] = 8'h41; vt[0].syms[5] = 8'h42;
        vt[0].nsyms = 6; vt[0].exp_n = 3;
        vt[0].exp_ent[0] = 15'h1043;
        vt[0].exp_ent[1] = 15'h1082;
        vt[0].exp_ent[2] = 15'h10C1;
        for (int i = 0; i < 9; i++) vt[1].syms[i] = 8'(i);
        vt[1].nsyms = 9; vt[1].exp_n = 8; vt[1].exp_ovf = 1'b1;
        for (int i = 0; i < 8; i++) vt[1].exp_ent[i] = 15'((i << 6) | 1);
        for (int i = 0; i < 5; i++) vt[2].syms[i] = 8'h7E;
        vt[2].nsyms = 5; vt[2].exp_n = 1;
        vt[2].exp_ent[0] = 15'h1F85;
        vt[3].syms[0] = 8'h10; vt[3].syms[1] = 8'h20;
        vt[3].syms[2] = 8'h10; vt[3].syms[3] = 8'h30;
        vt[3].syms[4] = 8'h20; vt[3].syms[5] = 8'h10;
        vt[3].nsyms = 6; vt[3].exp_n = 3; vt[3].hold_aa = 1'b1;
        vt[3].exp_ent[0] = 15'h0403;
        vt[3].exp_ent[1] = 15'h0802;
        vt[3].exp_ent[2] = 15'h0C01;
        vt[4].syms[0] = 8'hAA;
        vt[4].nsyms = 1; vt[4].exp_n = 1;
        vt[4].exp_ent[0] = 15'h2A81;

        rst       = 1'b0;
        sym_valid = 1'b0;
        sym_data  = 8'h00;
        sym_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", sym_ready, 1);
        chk("rst_down", down, 0);
        chk("rst_gd", group_data, 0);
        chk("rst_nsym", n_sym, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", err_ovf, 0);
        rst = 1'b1;

        sym_last = 1'b1;
        @(negedge clk);
        sym_last = 1'b0;
        chk("last_only_down", down, 0);
        chk("last_only_ready", sym_ready, 1);

        for (int i = 0; i < 5; i++) begin
            send(vt[i]);
            collect(vt[i]);
        end

        v70 = '0;
        v70.exp_n = 1;
        v70.exp_ent[0] = 15'h157E;
`ifdef HUFF_FREQ_SAT_EN
        v70.exp_ovf = 1'b0;
`else
        v70.exp_ovf = 1'b1;
`endif
        send_rep(8'h55, 70);
        collect(v70);

        vr = '0;
        vr.syms[0] = 8'h11; vr.syms[1] = 8'h22;
        vr.syms[2] = 8'h33; vr.syms[3] = 8'h44;
        vr.nsyms = 4;
        send(vr);
        @(negedge clk);
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        @(negedge clk);
        chk("rm_down1", down, 1);
        chk("rm_ent0", group_data, 15'h0441);
        @(negedge clk);
        chk("rm_down2", down, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rm_down_drop", down, 0);
        chk("rm_nsym", n_sym, 0);
        chk("rm_ready", sym_ready, 1);
        dcnt = 0;
        if (done) dcnt++;
        repeat (4) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("rm_no_done", dcnt, 0);

        v1 = '0;
        v1.syms[0] = 8'h5A;
        v1.nsyms = 1; v1.exp_n = 1;
        v1.exp_ent[0] = 15'h1681;
        send(v1);
        collect(v1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
